mor1kx_trace_capture_buffer: RTL and testbench

//  Downstream consumer of the traceport and of the start/stop trace window from the traceport monitor.

---
 rtl/mor1kx_trace_capture_buffer.sv | 137 +++++++++++++
 tb/tb_mor1kx_trace_capture_buffer.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mor1kx_trace_capture_buffer.sv
// Trace capture buffer: stores retired instructions into a circular buffer while the
// trace window is open, and presents them on a first-word fall-through read port.
module mor1kx_trace_capture_buffer #(
  parameter int OPTION_OPERAND_WIDTH = 32,
  parameter int OPTION_RF_ADDR_WIDTH = 5,
  parameter int DEPTH_LOG2           = 6,
  parameter bit STOP_ON_FULL         = 1'b0
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            traceport_exec_valid,
  input  logic [31:0]                     traceport_exec_pc,
  input  logic [31:0]                     traceport_exec_insn,
  input  logic [OPTION_OPERAND_WIDTH-1:0] traceport_exec_wbdata,
  input  logic [OPTION_RF_ADDR_WIDTH-1:0] traceport_exec_wbreg,
  input  logic                            traceport_exec_wben,
  input  logic                            start_trace,
  input  logic                            stop_trace,
  input  logic                            flush,
  output logic                            rd_valid,
  input  logic                            rd_ready,
  output logic [31:0]                     rd_pc,
  output logic [31:0]                     rd_insn,
  output logic [OPTION_OPERAND_WIDTH-1:0] rd_wbdata,
  output logic [OPTION_RF_ADDR_WIDTH-1:0] rd_wbreg,
  output logic                            rd_wben,
  output logic [31:0]                     rd_stamp,
  output logic [DEPTH_LOG2:0]             level,
  output logic [15:0]                     dropped,
  output logic                            capturing
);

  localparam int OW    = OPTION_OPERAND_WIDTH;
  localparam int RW    = OPTION_RF_ADDR_WIDTH;
  localparam int EW    = 32 + 32 + OW + RW + 1 + 32;
  localparam int DEPTH = 2 ** DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL_LEVEL = (DEPTH_LOG2 + 1)'(DEPTH);

  typedef enum logic {
    IDLE    = 1'b0,
    CAPTURE = 1'b1
  } state_t;

  state_t                state_q, state_d;
  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
  logic [DEPTH_LOG2:0]   level_q, level_d;
  logic [15:0]           dropped_q, dropped_d;
  logic [31:0]           stamp_q;

  logic [EW-1:0] mem [DEPTH];
  logic [EW-1:0] wr_entry;
  logic [EW-1:0] rd_entry;

  logic push, pop, full, we, drop;

  assign push     = (state_q == CAPTURE) && traceport_exec_valid;
  assign pop      = rd_valid && rd_ready;
  assign full     = (level_q == FULL_LEVEL);
  assign wr_entry = {traceport_exec_pc, traceport_exec_insn, traceport_exec_wbdata,
                     traceport_exec_wbreg, traceport_exec_wben, stamp_q};

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_trace && !stop_trace) state_d = CAPTURE;
      CAPTURE: if (stop_trace) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    we       = 1'b0;
    drop     = 1'b0;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else if (push && (pop || !full)) begin
      we       = 1'b1;
      wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
      else     level_d  = level_q + 1'b1;
    end else if (push) begin
      // Full with no pop: either evict the oldest entry or reject the new one.
      drop = 1'b1;
      if (!STOP_ON_FULL) begin
        we       = 1'b1;
        wr_ptr_d = wr_ptr_q + 1'b1;
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
    end else if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
      level_d  = level_q - 1'b1;
    end
  end

  always_comb begin
    dropped_d = dropped_q;
    if (flush)                             dropped_d = '0;
    else if (drop && (dropped_q != 16'hFFFF)) dropped_d = dropped_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      level_q   <= '0;
      dropped_q <= '0;
      stamp_q   <= '0;
    end else begin
      state_q   <= state_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      level_q   <= level_d;
      dropped_q <= dropped_d;
      stamp_q   <= stamp_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (we && !rst) mem[wr_ptr_q] <= wr_entry;
  end

  // Head entry is read combinationally so the consumer sees it with zero latency.
  assign rd_entry  = mem[rd_ptr_q];
  assign rd_valid  = (level_q != '0);
  assign {rd_pc, rd_insn, rd_wbdata, rd_wbreg, rd_wben, rd_stamp} = rd_valid ? rd_entry : '0;
  assign level     = level_q;
  assign dropped   = dropped_q;
  assign capturing = (state_q == CAPTURE);

endmodule

// File: tb/tb_mor1kx_trace_capture_buffer.sv
// Bench for the trace capture buffer: two instances (overwrite / drop-newest) share
// stimulus and are checked every cycle against a queue-based model.
module tb_mor1kx_trace_capture_buffer;

  localparam int DL    = 6;
  localparam int DEPTH = 64;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] insn;
    logic [31:0] wbdata;
    logic [4:0]  wbreg;
    logic        wben;
    logic [31:0] stamp;
  } ent_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic v = 1'b0, wben = 1'b0, start = 1'b0, stop = 1'b0, flush = 1'b0, ready = 1'b0;
  logic [31:0] pc = '0, insn = '0, wbdata = '0;
  logic [4:0]  wbreg = '0;

  logic        rv     [2];
  logic [31:0] rpc    [2];
  logic [31:0] rinsn  [2];
  logic [31:0] rwbd   [2];
  logic [4:0]  rwbr   [2];
  logic        rwben  [2];
  logic [31:0] rstamp [2];
  logic [DL:0] lvl    [2];
  logic [15:0] drp    [2];
  logic        cap    [2];

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  for (genvar gi = 0; gi < 2; gi++) begin : g_dut
    mor1kx_trace_capture_buffer #(
      .OPTION_OPERAND_WIDTH(32),
      .OPTION_RF_ADDR_WIDTH(5),
      .DEPTH_LOG2(DL),
      .STOP_ON_FULL(gi == 1)
    ) u_dut (
      .clk                  (clk),
      .rst                  (rst),
      .traceport_exec_valid (v),
      .traceport_exec_pc    (pc),
      .traceport_exec_insn  (insn),
      .traceport_exec_wbdata(wbdata),
      .traceport_exec_wbreg (wbreg),
      .traceport_exec_wben  (wben),
      .start_trace          (start),
      .stop_trace           (stop),
      .flush                (flush),
      .rd_valid             (rv[gi]),
      .rd_ready             (ready),
      .rd_pc                (rpc[gi]),
      .rd_insn              (rinsn[gi]),
      .rd_wbdata            (rwbd[gi]),
      .rd_wbreg             (rwbr[gi]),
      .rd_wben              (rwben[gi]),
      .rd_stamp             (rstamp[gi]),
      .level                (lvl[gi]),
      .dropped              (drp[gi]),
      .capturing            (cap[gi])
    );
  end

  task automatic chk(input string nm, input int m, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s dut%0d t=%0t actual=%0h required=%0h", nm, m, $time, act, exp);
    end
  endtask

  // Reference model: mq0 overwrites the oldest when full, mq1 rejects the newest.
  ent_t        mq0[$];
  ent_t        mq1[$];
  logic [15:0] md0, md1;
  bit          mst;
  logic [31:0] mstamp;
  bit          mvalid = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      mq0.delete();
      mq1.delete();
      md0 = '0;
      md1 = '0;
      mst = 1'b0;
      mstamp = '0;
      mvalid = 1'b1;
    end else begin
      ent_t e;
      bit   push;
      e    = {pc, insn, wbdata, wbreg, wben, mstamp};
      push = mst && v;
      if (flush) begin
        mq0.delete();
        mq1.delete();
        md0 = '0;
        md1 = '0;
      end else begin
        if (ready && mq0.size() != 0) void'(mq0.pop_front());
        if (ready && mq1.size() != 0) void'(mq1.pop_front());
        if (push) begin
          if (mq0.size() == DEPTH) begin
            void'(mq0.pop_front());
            if (md0 != 16'hFFFF) md0++;
          end
          mq0.push_back(e);
          if (mq1.size() < DEPTH) mq1.push_back(e);
          else if (md1 != 16'hFFFF) md1++;
        end
      end
      if (!mst && start && !stop) mst = 1'b1;
      else if (mst && stop)       mst = 1'b0;
      mstamp++;
    end
  end

  always @(negedge clk) begin
    if (mvalid) begin
      for (int m = 0; m < 2; m++) begin
        ent_t        h;
        int          sz;
        logic [15:0] d;
        sz = (m == 0) ? mq0.size() : mq1.size();
        d  = (m == 0) ? md0 : md1;
        h  = '0;
        if (sz != 0) h = (m == 0) ? mq0[0] : mq1[0];
        chk("rd_valid",  m, 32'(rv[m]),     32'(sz != 0));
        chk("level",     m, 32'(lvl[m]),    32'(sz));
        chk("dropped",   m, 32'(drp[m]),    32'(d));
        chk("capturing", m, 32'(cap[m]),    32'(mst));
        chk("rd_pc",     m, rpc[m],         h.pc);
        chk("rd_insn",   m, rinsn[m],       h.insn);
        chk("rd_wbdata", m, rwbd[m],        h.wbdata);
        chk("rd_wbreg",  m, 32'(rwbr[m]),   32'(h.wbreg));
        chk("rd_wben",   m, 32'(rwben[m]),  32'(h.wben));
        chk("rd_stamp",  m, rstamp[m],      h.stamp);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  task automatic retire(input logic [31:0] p);
    v = 1'b1; pc = p; insn = ~p; wbdata = p ^ 32'h5A5A_0000;
    wbreg = p[6:2]; wben = p[2];
  endtask

  initial begin
    tick();
    tick();
    // Window opens; three retires with no consumer.
    rst = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    retire(32'h100); tick();
    retire(32'h104); tick();
    retire(32'h108); tick();
    v = 1'b0;
    for (int m = 0; m < 2; m++) begin
      chk("lit_level3", m, 32'(lvl[m]), 32'd3);
      chk("lit_pc100",  m, rpc[m], 32'h100);
      chk("lit_stamp1", m, rstamp[m], 32'd1);
      chk("lit_drop0",  m, 32'(drp[m]), 32'd0);
    end

    // Overfill by two entries.
    flush = 1'b1; tick(); flush = 1'b0;
    for (int i = 0; i < 66; i++) begin
      retire(32'h1000 + 32'(4 * i)); tick();
    end
    v = 1'b0;
    for (int m = 0; m < 2; m++) begin
      chk("lit_full",  m, 32'(lvl[m]), 32'd64);
      chk("lit_drop2", m, 32'(drp[m]), 32'd2);
    end
    chk("lit_head_ovw",  0, rpc[0], 32'h1008);
    chk("lit_head_stop", 1, rpc[1], 32'h1000);

    // Push and pop together while full.
    retire(32'h2000); ready = 1'b1; tick();
    v = 1'b0;
    for (int m = 0; m < 2; m++) begin
      chk("lit_full_pp",  m, 32'(lvl[m]), 32'd64);
      chk("lit_drop_pp",  m, 32'(drp[m]), 32'd2);
    end
    chk("lit_head_pp", 0, rpc[0], 32'h100C);
    chk("lit_head_pp", 1, rpc[1], 32'h1004);
    for (int i = 0; i < 63; i++) tick();
    for (int m = 0; m < 2; m++) begin
      chk("lit_tail", m, rpc[m], 32'h2000);
      chk("lit_lvl1", m, 32'(lvl[m]), 32'd1);
    end
    tick();
    ready = 1'b0;
    for (int m = 0; m < 2; m++) chk("lit_empty", m, 32'(rv[m]), 32'd0);

    // Stop with a coinciding retire; start+stop together from IDLE.
    retire(32'h3000); stop = 1'b1; tick();
    stop = 1'b0; retire(32'h3004); tick();
    start = 1'b1; stop = 1'b1; retire(32'h3008); tick();
    start = 1'b0; stop = 1'b0; v = 1'b0; tick();
    for (int m = 0; m < 2; m++) begin
      chk("lit_idle",     m, 32'(cap[m]), 32'd0);
      chk("lit_stop_lvl", m, 32'(lvl[m]), 32'd1);
      chk("lit_stop_pc",  m, rpc[m], 32'h3000);
    end
    ready = 1'b1; tick(); ready = 1'b0;

    // Flush with five entries and a concurrent pop/push.
    start = 1'b1; v = 1'b0; tick(); start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      retire(32'h4000 + 32'(4 * i)); tick();
    end
    flush = 1'b1; ready = 1'b1; retire(32'h5000); tick();
    flush = 1'b0; ready = 1'b0; v = 1'b0;
    for (int m = 0; m < 2; m++) begin
      chk("lit_fl_lvl",  m, 32'(lvl[m]), 32'd0);
      chk("lit_fl_val",  m, 32'(rv[m]), 32'd0);
      chk("lit_fl_drop", m, 32'(drp[m]), 32'd0);
      chk("lit_fl_cap",  m, 32'(cap[m]), 32'd1);
    end

    // Randomized traffic with phases of slow, medium and fast draining.
    for (int i = 0; i < 4000; i++) begin
      int rp;
      rp     = ((i / 300) % 3 == 0) ? 10 : (((i / 300) % 3 == 1) ? 50 : 90);
      rst    = ($urandom_range(0, 999) < 1);
      flush  = ($urandom_range(0, 999) < 2);
      start  = ($urandom_range(0, 99) < 8);
      stop   = ($urandom_range(0, 99) < 3);
      ready  = ($urandom_range(0, 99) < rp);
      v      = ($urandom_range(0, 99) < 70);
      pc     = $urandom;
      insn   = $urandom;
      wbdata = $urandom;
      wbreg  = 5'($urandom_range(0, 31));
      wben   = 1'($urandom_range(0, 1));
      tick();
    end
    rst = 1'b0; flush = 1'b0; start = 1'b0; stop = 1'b0; ready = 1'b0; v = 1'b0;
    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
